// File: rtl/pwm_audio_out.sv
// Audio output stage: sample FIFO, per-sample rate divider and glitch-free PWM modulator
// driving the mono audio jack, with a saturating underrun counter for debug.
`timescale 1ns/1ps
module pwm_audio_out #(
  parameter int unsigned SAMPLE_DIV = 2083,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic                          aud_sd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_count,
  input  logic                          underrun_clr
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned DW         = $clog2(SAMPLE_DIV);
  localparam int unsigned DivLastInt = SAMPLE_DIV - 1;
  localparam logic [DW-1:0]       DivLast   = DivLastInt[DW-1:0];
  localparam logic [AW:0]         LevelFull = FIFO_DEPTH[AW:0];
  localparam logic [PWM_BITS-1:0] PwmLast   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DutyMid   = {1'b1, {(PWM_BITS-1){1'b0}}};

  logic [15:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
  logic [15:0]         cur_sample_q, cur_sample_d;
  logic [15:0]         underrun_q, underrun_d;
  logic                pwm_out_q, pwm_out_d;
  logic                aud_sd_q, aud_sd_d;
  logic                push, pop, tick;
  logic                unused_lsbs;

  assign sample_ready   = (level_q != LevelFull);
  assign fifo_level     = level_q;
  assign underrun_count = underrun_q;
  assign pwm_out        = pwm_out_q;
  assign aud_sd         = aud_sd_q;
  assign unused_lsbs    = ^cur_sample_q[15-PWM_BITS:0];

  always_comb begin
    push = sample_valid && sample_ready;
    tick = enable && (div_cnt_q == DivLast);
    // An empty FIFO on a tick is an underrun even if a push lands in the same cycle.
    pop  = tick && (level_q != '0);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (!enable || tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    cur_sample_d = pop ? mem_q[rd_ptr_q] : cur_sample_q;

    underrun_d = underrun_q;
    if (underrun_clr) begin
      underrun_d = '0;
    end else if (tick && (level_q == '0) && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end

    pwm_cnt_d = enable ? pwm_cnt_q + 1'b1 : '0;

    // Duty only changes at a period boundary so no PWM pulse is ever truncated.
    if (enable && (pwm_cnt_q == PwmLast)) begin
      duty_active_d = cur_sample_q[15 -: PWM_BITS];
    end else begin
      duty_active_d = duty_active_q;
    end

    pwm_out_d = enable && (pwm_cnt_q < duty_active_q);
    aud_sd_d  = enable;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      div_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      duty_active_q <= DutyMid;
      cur_sample_q  <= 16'h8000;
      underrun_q    <= '0;
      pwm_out_q     <= 1'b0;
      aud_sd_q      <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      div_cnt_q     <= div_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_active_q <= duty_active_d;
      cur_sample_q  <= cur_sample_d;
      underrun_q    <= underrun_d;
      pwm_out_q     <= pwm_out_d;
      aud_sd_q      <= aud_sd_d;
    end
  end

endmodule
